// File: rtl/adder_serial_nbits.sv
// Digit-serial adder/subtractor.
// Each operation processes P_DIGIT bits per cycle over N = P_WIDTH/P_DIGIT RUN cycles.
// The registered result {carry, sum} and the two's-complement overflow flag are loaded
// on the completion edge and held until the next completion or reset.
module adder_serial_nbits #(
  parameter int unsigned P_WIDTH = 6,
  parameter int unsigned P_DIGIT = 1
) (
  input  logic               i_w_clk,
  input  logic               i_w_reset,
  input  logic               i_w_start,
  input  logic               i_w_sub,
  input  logic [P_WIDTH-1:0] i_w_a,
  input  logic [P_WIDTH-1:0] i_w_b,
  output logic [P_WIDTH:0]   o_w_s,
  output logic               o_w_ovf,
  output logic               o_w_busy,
  output logic               o_w_done
);

  localparam int unsigned N    = P_WIDTH / P_DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Operand shift registers; b holds B' (B or ~B depending on mode).
  logic [P_WIDTH-1:0] a_q, a_d;
  logic [P_WIDTH-1:0] b_q, b_d;
  // Partial sum, filled from the MSB side one digit per RUN cycle.
  logic [P_WIDTH-1:0] sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Held result registers.
  logic [P_WIDTH:0]   s_q, s_d;
  logic               ovf_q, ovf_d;

  // Digit adder results.
  logic [P_DIGIT-1:0]         dig_sum;
  logic                       dig_cout;
  logic                       dig_cmsb;
  logic [P_WIDTH+P_DIGIT-1:0] sum_cat;
  logic [P_WIDTH-1:0]         sum_shift;

  // Ripple add of the low digit of A, B' and the carry; also expose the carry into the MSB.
  always_comb begin : digit_add
    logic c;
    c        = carry_q;
    dig_cmsb = carry_q;
    dig_sum  = '0;
    for (int i = 0; i < int'(P_DIGIT); i++) begin
      dig_cmsb   = c;
      dig_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    dig_cout = c;
  end

  // Insert the new digit at the top of the sum register, dropping the oldest low bits.
  always_comb begin : sum_insert
    sum_cat   = {dig_sum, sum_q};
    sum_shift = sum_cat[P_WIDTH+P_DIGIT-1:P_DIGIT];
  end

  // FSM next-state and datapath update.
  always_comb begin : next_state
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (i_w_start) begin
          a_d     = i_w_a;
          b_d     = i_w_sub ? ~i_w_b : i_w_b;
          carry_d = i_w_sub;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> P_DIGIT;
        b_d     = b_q >> P_DIGIT;
        carry_d = dig_cout;
        sum_d   = sum_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Final digit: its top bit is the operand MSB.
          s_d     = {dig_cout, sum_shift};
          ovf_d   = dig_cmsb ^ dig_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_w_s    = s_q;
  assign o_w_ovf  = ovf_q;
  assign o_w_busy = (state_q == StRun);
  assign o_w_done = (state_q == StDone);

endmodule

// File: tb/tb_adder_serial_nbits.sv
// Bench for adder_serial_nbits: four instances (P_DIGIT 1,2,3,6) with a behavioural
// per-instance model, a per-cycle compare process, directed cases on the P_DIGIT=1
// instance and randomized back-to-back traffic on all instances.
module tb_adder_serial_nbits;

  localparam int NI = 4;

  function automatic int digit_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 6;
    endcase
  endfunction

  function automatic int n_of(input int i);
    return 6 / digit_of(i);
  endfunction

  // Reference: {carry, sum} of a + b or a + ~b + 1.
  function automatic logic [6:0] ref_s(input logic [5:0] av, input logic [5:0] bv,
                                       input logic sv);
    int r;
    int x;
    int y;
    x = int'(av);
    y = int'(bv);
    r = sv ? (x + (63 - y) + 1) : (x + y);
    return r[6:0];
  endfunction

  // Reference: signed result out of 6-bit range.
  function automatic logic ref_ovf(input logic [5:0] av, input logic [5:0] bv,
                                   input logic sv);
    int sa;
    int sb;
    int r;
    sa = (av >= 6'd32) ? int'(av) - 64 : int'(av);
    sb = (bv >= 6'd32) ? int'(bv) - 64 : int'(bv);
    r  = sv ? (sa - sb) : (sa + sb);
    return (r > 31) || (r < -32);
  endfunction

  logic       clk;
  logic       rst   [NI];
  logic       start [NI];
  logic       sub   [NI];
  logic [5:0] a     [NI];
  logic [5:0] b     [NI];
  logic [6:0] s     [NI];
  logic       ovf   [NI];
  logic       busy  [NI];
  logic       done  [NI];

  int         m_phase [NI];
  logic [6:0] m_s     [NI];
  logic       m_ovf   [NI];

  int nchk;
  int nerr;
  bit chk_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int inst, input logic [7:0] act,
                       input logic [7:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s inst%0d t=%0t: got %0d, expected %0d", nm, inst, $time, act, expv);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int D = digit_of(gi);
    localparam int N = 6 / D;

    int         phase;
    logic [6:0] exp_s;
    logic [6:0] pend_s;
    logic       exp_ovf;
    logic       pend_ovf;

    adder_serial_nbits #(
      .P_WIDTH(6),
      .P_DIGIT(D)
    ) u_dut (
      .i_w_clk  (clk),
      .i_w_reset(rst[gi]),
      .i_w_start(start[gi]),
      .i_w_sub  (sub[gi]),
      .i_w_a    (a[gi]),
      .i_w_b    (b[gi]),
      .o_w_s    (s[gi]),
      .o_w_ovf  (ovf[gi]),
      .o_w_busy (busy[gi]),
      .o_w_done (done[gi])
    );

    // Model: phase 0 = idle, 1..N = run cycles, N+1 = done cycle.
    always @(posedge clk or posedge rst[gi]) begin
      if (rst[gi]) begin
        phase    <= 0;
        exp_s    <= '0;
        exp_ovf  <= 1'b0;
        pend_s   <= '0;
        pend_ovf <= 1'b0;
      end else if (phase == 0) begin
        if (start[gi]) begin
          pend_s   <= ref_s(a[gi], b[gi], sub[gi]);
          pend_ovf <= ref_ovf(a[gi], b[gi], sub[gi]);
          phase    <= 1;
        end
      end else if (phase <= N) begin
        phase <= phase + 1;
        if (phase == N) begin
          exp_s   <= pend_s;
          exp_ovf <= pend_ovf;
        end
      end else begin
        phase <= 0;
      end
    end

    assign m_phase[gi] = phase;
    assign m_s[gi]     = exp_s;
    assign m_ovf[gi]   = exp_ovf;
  end

  // Per-cycle comparison of every instance against its model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("busy", i, {7'd0, busy[i]}, {7'd0, (m_phase[i] >= 1 && m_phase[i] <= n_of(i))});
        check("done", i, {7'd0, done[i]}, {7'd0, (m_phase[i] == n_of(i) + 1)});
        check("s", i, {1'b0, s[i]}, {1'b0, m_s[i]});
        check("ovf", i, {7'd0, ovf[i]}, {7'd0, m_ovf[i]});
      end
    end
  end

  // Start one operation on instance 0 and wait (bounded) for its done cycle.
  task automatic run_op(input logic [5:0] av, input logic [5:0] bv, input logic sv,
                        output int busy_cycles, output bit got_done);
    @(negedge clk);
    start[0] = 1'b1;
    a[0]     = av;
    b[0]     = bv;
    sub[0]   = sv;
    @(negedge clk);
    start[0]    = 1'b0;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      if (done[0]) begin
        got_done = 1'b1;
      end else begin
        if (busy[0]) busy_cycles++;
        @(negedge clk);
      end
    end
    check("done_seen", 0, {7'd0, got_done}, 8'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  bc;
    bit  gd;
    int  ndone;
    nchk   = 0;
    nerr   = 0;
    chk_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rst[i]   = 1'b0;
      start[i] = 1'b0;
      sub[i]   = 1'b0;
      a[i]     = '0;
      b[i]     = '0;
    end
    #1;
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;
    chk_en = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_s", 0, {1'b0, s[0]}, 8'd0);
    check("rst_ovf", 0, {7'd0, ovf[0]}, 8'd0);
    check("rst_busy", 0, {7'd0, busy[0]}, 8'd0);
    check("rst_done", 0, {7'd0, done[0]}, 8'd0);
    #2;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;

    // 63 + 63: six busy cycles, result 126, no overflow.
    run_op(6'd63, 6'd63, 1'b0, bc, gd);
    check("busy_len", 0, 8'(bc), 8'd6);
    check("s_63p63", 0, {1'b0, s[0]}, 8'd126);
    check("ovf_63p63", 0, {7'd0, ovf[0]}, 8'd0);

    run_op(6'd31, 6'd1, 1'b0, bc, gd);
    check("s_31p1", 0, {1'b0, s[0]}, 8'd32);
    check("ovf_31p1", 0, {7'd0, ovf[0]}, 8'd1);
    run_op(6'd5, 6'd9, 1'b1, bc, gd);
    check("s_5m9", 0, {1'b0, s[0]}, 8'd60);
    check("ovf_5m9", 0, {7'd0, ovf[0]}, 8'd0);
    run_op(6'd0, 6'd0, 1'b1, bc, gd);
    check("s_0m0", 0, {1'b0, s[0]}, 8'd64);
    check("ovf_0m0", 0, {7'd0, ovf[0]}, 8'd0);

    // 10 + 20 with start pulses during RUN and DONE that must be ignored.
    @(negedge clk);
    start[0] = 1'b1;
    a[0]     = 6'd10;
    b[0]     = 6'd20;
    sub[0]   = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    ndone    = 0;
    @(negedge clk);
    start[0] = 1'b1;
    a[0]     = 6'd1;
    b[0]     = 6'd1;
    sub[0]   = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    gd       = 1'b0;
    for (int k = 0; k < 20 && !gd; k++) begin
      if (done[0]) gd = 1'b1;
      else @(negedge clk);
    end
    check("done_seen_req34", 0, {7'd0, gd}, 8'd1);
    check("s_10p20", 0, {1'b0, s[0]}, 8'd30);
    ndone    = 1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done[0]) ndone++;
      @(negedge clk);
    end
    check("one_done", 0, 8'(ndone), 8'd1);
    check("s_hold", 0, {1'b0, s[0]}, 8'd30);

    // Reset in the third RUN cycle of 63 + 1.
    @(negedge clk);
    start[0] = 1'b1;
    a[0]     = 6'd63;
    b[0]     = 6'd1;
    sub[0]   = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst[0] = 1'b1;
    #1;
    check("arst_s", 0, {1'b0, s[0]}, 8'd0);
    check("arst_ovf", 0, {7'd0, ovf[0]}, 8'd0);
    check("arst_busy", 0, {7'd0, busy[0]}, 8'd0);
    check("arst_done", 0, {7'd0, done[0]}, 8'd0);
    @(negedge clk);
    #2;
    rst[0] = 1'b0;
    // Start on the first edge after reset release.
    start[0] = 1'b1;
    a[0]     = 6'd2;
    b[0]     = 6'd3;
    sub[0]   = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    gd       = 1'b0;
    for (int k = 0; k < 20 && !gd; k++) begin
      if (done[0]) gd = 1'b1;
      else @(negedge clk);
    end
    check("done_seen_after_rst", 0, {7'd0, gd}, 8'd1);
    check("s_2p3", 0, {1'b0, s[0]}, 8'd5);

    // Randomized back-to-back traffic on every instance.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        start[i] = ($urandom_range(0, 3) != 0);
        sub[i]   = 1'($urandom_range(0, 1));
        a[i]     = 6'($urandom_range(0, 63));
        b[i]     = 6'($urandom_range(0, 63));
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    repeat (12) @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/adder_serial_nbits.md
ADDER_SERIAL_NBITS -- requirements
Module: adder_serial_nbits

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 6, giving the operand width in bits.
REQ-002 The block SHALL have parameter P_DIGIT, default 1, giving the bits processed per cycle; P_DIGIT SHALL divide P_WIDTH exactly, and N = P_WIDTH/P_DIGIT.
REQ-003 i_w_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_w_reset  input  1  asynchronous, active-high reset.
REQ-005 i_w_start  input  1  request to start an operation; sampled only in IDLE.
REQ-006 i_w_sub  input  1  mode: 0 = a+b, 1 = a-b; sampled with i_w_start.
REQ-007 i_w_a  input  P_WIDTH  operand A; sampled with i_w_start.
REQ-008 i_w_b  input  P_WIDTH  operand B; sampled with i_w_start.
REQ-009 o_w_s  output  P_WIDTH+1  registered result: {carry out, sum}.
REQ-010 o_w_ovf  output  1  registered two's-complement overflow flag of the last result.
REQ-011 o_w_busy  output  1  high while the FSM is in RUN.
REQ-012 o_w_done  output  1  one-cycle completion pulse; high only in DONE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE with i_w_start=1 at a rising edge, the block SHALL capture i_w_a, the operand B' = i_w_b (add) or ~i_w_b (sub), and carry-in = i_w_sub; it SHALL reset the digit counter to 0 and go to RUN.
REQ-015 Each RUN cycle SHALL add the least significant P_DIGIT bits of A, B' and the carry register, then shift the digit result into the sum register from the MSB side.
REQ-016 Each RUN cycle SHALL shift A and B' right by P_DIGIT and increment the digit counter.
REQ-017 After the Nth RUN cycle the FSM SHALL go to DONE.
REQ-018 On that same edge, o_w_s SHALL load {final carry, sum}.
REQ-019 On that same edge, o_w_ovf SHALL load (carry into the MSB) XOR (carry out of the MSB).
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-021 Latency: with start sampled at edge 0, o_w_done SHALL be high in the cycle after edge N, and the FSM SHALL be back in IDLE after edge N+1.
REQ-022 Minimum start-to-start spacing SHALL be N+2 cycles.
REQ-023 i_w_start SHALL be ignored in RUN and DONE; there is no queueing, and captured operands are unaffected.
REQ-024 Input changes during RUN or DONE SHALL have no effect.
REQ-025 o_w_s and o_w_ovf SHALL hold their values from completion until the next completion or reset.
REQ-026 In sub mode, o_w_s[P_WIDTH] SHALL equal the carry out of A + ~B + 1 (1 = no borrow), and o_w_s[P_WIDTH-1:0] SHALL equal (A-B) mod 2^P_WIDTH.
REQ-027 With P_DIGIT = P_WIDTH (N=1), RUN SHALL last exactly one cycle.
REQ-028 The carry chain SHALL wrap no state across operations: each start reloads the carry from i_w_sub.

Reset
REQ-029 While i_w_reset=1, the FSM SHALL be in IDLE, and o_w_s, o_w_ovf, o_w_busy, o_w_done, the counter and the internal registers SHALL all be 0, without waiting for a clock edge.
REQ-030 Reset asserted mid-RUN SHALL abort the operation; no o_w_done pulse SHALL be produced for the aborted operation.
REQ-031 The first rising edge after reset deassertion with i_w_start=1 SHALL start a new operation normally.

Verification (P_WIDTH=6, P_DIGIT=1 unless stated)
REQ-032 a=63, b=63, add -> busy for 6 cycles, then done for 1 cycle; o_w_s=126, ovf=0.
REQ-033 a=31, b=1, add -> o_w_s=32, ovf=1; then a=5, b=9, sub -> o_w_s=60 (bit6=0), ovf=0; then a=0, b=0, sub -> o_w_s=64, ovf=0.
REQ-034 Start a=10, b=20; pulse start with a=1, b=1 during RUN and again in DONE -> exactly one done pulse, o_w_s=30.
REQ-035 Reset asserted in the 3rd RUN cycle of a=63+b=1 -> all outputs 0 asynchronously, no done pulse; the next start of 2+3 -> o_w_s=5.
REQ-036 Exhaustive sweep, for P_DIGIT in {1,2,3,6}: all 64x64 operand pairs in both modes, back to back -> o_w_s and o_w_ovf match the reference model, and done occurs exactly N+1 cycles after each start edge.
